// File: rtl/fir_tap_sequencer.sv
// Control FSM for the FIR delay line and shared MAC: captures a sample, shifts the line,
// walks the MAC over every tap, waits out the MAC pipeline and hands off the result.
module fir_tap_sequencer #(
    parameter int unsigned TAPS    = 8,
    parameter int unsigned TAP_W   = 3,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sample,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] sample_q,
    output logic              shift_en,
    output logic              line_clear,
    output logic [TAP_W-1:0]  tap_sel,
    output logic              acc_load,
    output logic              acc_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       sample_count
);

    localparam int unsigned DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StFlush,
        StShift,
        StMac,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  smp_q, smp_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [15:0]        count_q, count_d;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StInit;
            smp_q   <= '0;
            tap_q   <= '0;
            drn_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            tap_q   <= tap_d;
            drn_q   <= drn_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        tap_d   = tap_q;
        drn_d   = drn_q;
        count_d = count_q;
        unique case (state_q)
            StInit:  state_d = StIdle;
            StIdle: begin
                // Flush wins; the pending sample stays on in_valid until the next idle cycle.
                if (flush) begin
                    state_d = StFlush;
                end else if (in_valid) begin
                    smp_d   = in_sample;
                    state_d = StShift;
                end
            end
            StFlush: state_d = StIdle;
            StShift: begin
                tap_d   = '0;
                state_d = StMac;
            end
            StMac: begin
                if (tap_q == TAP_LAST) begin
                    drn_d   = '0;
                    state_d = StDrain;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StDrain: begin
                if (drn_q == DRN_LAST) begin
                    state_d = StDone;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Strobes decode from state registers only, so no input reaches an output combinationally.
    always_comb begin
        in_ready   = (state_q == StIdle);
        line_clear = (state_q == StInit) || (state_q == StFlush);
        shift_en   = (state_q == StShift);
        acc_en     = (state_q == StMac);
        acc_load   = (state_q == StMac) && (tap_q == '0);
        out_valid  = (state_q == StDone);
    end

    assign sample_q     = smp_q;
    assign tap_sel      = tap_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: vector table plus hand sequences and random traffic,
// every cycle checked against a latency-based reference model.
module tb_fir_tap_sequencer;

    localparam int TAPS    = 8;
    localparam int TAP_W   = 3;
    localparam int DATA_W  = 24;
    localparam int MAC_LAT = 2;
    localparam int DONE_T  = TAPS + MAC_LAT + 2;

    logic              clk;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_sample;
    logic              in_ready;
    logic              flush;
    logic [DATA_W-1:0] sample_q;
    logic              shift_en;
    logic              line_clear;
    logic [TAP_W-1:0]  tap_sel;
    logic              acc_load;
    logic              acc_en;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       sample_count;

    fir_tap_sequencer #(
        .TAPS   (TAPS),
        .TAP_W  (TAP_W),
        .DATA_W (DATA_W),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .in_ready    (in_ready),
        .flush       (flush),
        .sample_q    (sample_q),
        .shift_en    (shift_en),
        .line_clear  (line_clear),
        .tap_sel     (tap_sel),
        .acc_load    (acc_load),
        .acc_en      (acc_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: m_t counts cycles since acceptance (1 = shift cycle), -1 when no sample in flight.
    bit          m_init, m_flush, m_idle;
    int          m_t;
    logic [23:0] m_sample;
    logic [15:0] m_count;
    int          m_tap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (clear) begin
            m_init = 1; m_flush = 0; m_idle = 0; m_t = -1;
            m_sample = '0; m_count = '0; m_tap = 0;
        end else if (m_init || m_flush) begin
            m_init = 0; m_flush = 0; m_idle = 1;
        end else if (m_idle) begin
            if (flush) begin
                m_flush = 1; m_idle = 0;
            end else if (in_valid) begin
                m_sample = in_sample; m_t = 1; m_idle = 0;
            end
        end else if (m_t >= 0) begin
            if (m_t >= DONE_T) begin
                if (out_ready) begin
                    m_count = m_count + 16'd1; m_t = -1; m_idle = 1;
                end
            end else begin
                m_t++;
                if (m_t >= 2 && m_t <= TAPS + 1) m_tap = m_t - 2;
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
        chk("line_clear", {31'd0, line_clear}, {31'd0, m_init || m_flush});
        chk("shift_en", {31'd0, shift_en}, {31'd0, m_t == 1});
        chk("acc_en", {31'd0, acc_en}, {31'd0, m_t >= 2 && m_t <= TAPS + 1});
        chk("acc_load", {31'd0, acc_load}, {31'd0, m_t == 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_t >= DONE_T});
        chk("tap_sel", {29'd0, tap_sel}, m_tap);
        chk("sample_q", {8'd0, sample_q}, {8'd0, m_sample});
        chk("sample_count", {16'd0, sample_count}, {16'd0, m_count});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 60 && !in_ready; i++) tick();
        chk(name, {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [23:0] sample;
        int          ready_delay;
        bit          junk;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        int sh_cnt, acc_cnt, ld_cnt, ov_at, drop;
        int taps[$];

        vecs[0] = '{sample: 24'h123456, ready_delay: 0,  junk: 0, exp_count: 16'd2};
        vecs[1] = '{sample: 24'h800000, ready_delay: 20, junk: 1, exp_count: 16'd3};
        vecs[2] = '{sample: 24'hFFFFFF, ready_delay: 3,  junk: 0, exp_count: 16'd4};
        vecs[3] = '{sample: 24'h000000, ready_delay: 1,  junk: 1, exp_count: 16'd5};

        clear = 1; in_valid = 0; in_sample = '0; flush = 0; out_ready = 0;
        m_init = 0; m_flush = 0; m_idle = 0; m_t = -1; m_sample = '0; m_count = '0; m_tap = 0;
        #1;

        // Reset: two clear edges, then one INIT cycle.
        tick();
        tick();
        clear = 0;
        chk("rst_line_clear", {31'd0, line_clear}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_count", {16'd0, sample_count}, 32'd0);
        tick();
        chk("rst_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_line_clear_off", {31'd0, line_clear}, 32'd0);

        // Single sample with full-scale positive input.
        in_valid = 1; in_sample = 24'h7FFFFF; out_ready = 1;
        tick();
        in_valid = 0;
        chk("single_sample_q", {8'd0, sample_q}, 32'h7FFFFF);
        sh_cnt = 0; acc_cnt = 0; ld_cnt = 0; ov_at = -1;
        if (shift_en) sh_cnt++;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (shift_en) sh_cnt++;
            if (acc_en) begin
                taps.push_back(int'(tap_sel));
                acc_cnt++;
                if (acc_load) begin
                    ld_cnt++;
                    chk("single_load_tap", {29'd0, tap_sel}, 32'd0);
                end
            end
            if (out_valid && ov_at < 0) ov_at = i;
            if (in_ready) break;
        end
        chk("single_shift_cycles", sh_cnt, 32'd1);
        chk("single_acc_cycles", acc_cnt, 32'd8);
        chk("single_load_cycles", ld_cnt, 32'd1);
        foreach (taps[i]) chk("single_tap_seq", taps[i], i);
        chk("single_ov_latency", ov_at, 32'd12);
        chk("single_count", {16'd0, sample_count}, 32'd1);
        out_ready = 0;

        // Table vectors: varying samples, backpressure lengths and ignored inputs in DONE.
        for (int v = 0; v < 4; v++) begin
            wait_ready("vec_wait_ready");
            in_valid = 1; in_sample = vecs[v].sample;
            tick();
            in_valid = 0;
            for (int i = 0; i < 40 && !out_valid; i++) tick();
            chk("vec_ov_rise", {31'd0, out_valid}, 32'd1);
            if (vecs[v].junk) begin
                in_valid = 1; flush = 1; in_sample = ~vecs[v].sample;
            end
            drop = 0;
            for (int d = 0; d < vecs[v].ready_delay; d++) begin
                tick();
                if (!out_valid) drop++;
                if (in_ready) drop++;
            end
            chk("vec_bp_held", drop, 32'd0);
            out_ready = 1;
            tick();
            in_valid = 0; flush = 0; out_ready = 0;
            chk("vec_sample_q", {8'd0, sample_q}, {8'd0, vecs[v].sample});
            chk("vec_count", {16'd0, sample_count}, {16'd0, vecs[v].exp_count});
            tick();
            chk("vec_count_once", {16'd0, sample_count}, {16'd0, vecs[v].exp_count});
        end

        // Flush priority over a simultaneous sample.
        wait_ready("flush_wait_ready");
        flush = 1; in_valid = 1; in_sample = 24'hABCDEF;
        tick();
        flush = 0;
        chk("flush_line_clear", {31'd0, line_clear}, 32'd1);
        chk("flush_not_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_sample_kept", {8'd0, sample_q}, 32'h000000);
        tick();
        chk("flush_back_idle", {31'd0, in_ready}, 32'd1);
        chk("flush_line_clear_1cyc", {31'd0, line_clear}, 32'd0);
        tick();
        in_valid = 0;
        chk("flush_then_accept", {8'd0, sample_q}, 32'hABCDEF);
        chk("flush_then_shift", {31'd0, shift_en}, 32'd1);
        out_ready = 1;
        wait_ready("flush_finish");
        out_ready = 0;

        // Clear while the MAC is at tap 4.
        clear = 1;
        tick();
        clear = 0;
        tick();
        in_valid = 1; in_sample = 24'h00BEEF;
        tick();
        in_valid = 0;
        for (int i = 0; i < 20 && !(acc_en && tap_sel == 3'd4); i++) tick();
        chk("midmac_reach_tap4", {29'd0, tap_sel}, 32'd4);
        clear = 1;
        tick();
        clear = 0;
        chk("midmac_line_clear", {31'd0, line_clear}, 32'd1);
        chk("midmac_acc_en", {31'd0, acc_en}, 32'd0);
        chk("midmac_tap", {29'd0, tap_sel}, 32'd0);
        chk("midmac_sample_q", {8'd0, sample_q}, 32'd0);
        out_ready = 1;
        drop = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) drop++;
        end
        chk("midmac_no_ov", drop, 32'd0);
        chk("midmac_count", {16'd0, sample_count}, 32'd0);
        out_ready = 0;

        // Counter wrap from 0xFFFF.
        force dut.count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        #1;
        release dut.count_q;
        tick();
        chk("wrap_preload", {16'd0, sample_count}, 32'h0000FFFF);
        in_valid = 1; in_sample = 24'h000123; out_ready = 1;
        tick();
        in_valid = 0;
        wait_ready("wrap_finish");
        chk("wrap_count", {16'd0, sample_count}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            clear     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_sample = 24'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
